filter_out_requant: RTL and testbench

FILTER_OUT_REQUANT -- requirements
Module: filter_out_requant

---
 rtl/filter_out_requant.sv | 150 +++++++++++++++
 tb/tb_filter_out_requant.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_out_requant.sv
// Requantizes 19-bit filter samples to 8 bits, decimates them and buffers the results in a small output FIFO.
// Define FILTER_OUT_SAT_CNT_EN to add the 16-bit sat_cnt saturation counter port.
module filter_out_requant #(
    parameter int DEC_FACTOR = 4,
    parameter int SHIFT      = 7,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic signed [18:0] data_in,
    input  logic               out_ready,
    input  logic               clr_ovf,
    output logic signed [7:0]  out_data,
    output logic               out_valid,
    output logic               ovf_sticky,
    output logic               drop_sticky
`ifdef FILTER_OUT_SAT_CNT_EN
    ,
    output logic [15:0]        sat_cnt
`endif
);

    localparam int PW = (DEC_FACTOR > 1) ? $clog2(DEC_FACTOR) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [19:0] ROUND_BIAS = 20'd1 << (SHIFT - 1);

    logic signed [19:0] biased;
    logic signed [19:0] shifted;
    logic signed [7:0]  sat_val;
    logic               sat_hit;

    logic [PW-1:0]      phase;
    logic               keep;

    logic               s1_valid;
    logic signed [7:0]  s1_data;

    logic signed [7:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic               full;
    logic               pop;
    logic               push;
    logic               drop;

    // Adding half an LSB before the arithmetic shift rounds ties toward +infinity.
    always_comb begin
        biased  = {data_in[18], data_in} + ROUND_BIAS;
        shifted = biased >>> SHIFT;
        sat_val = shifted[7:0];
        sat_hit = 1'b0;
        if (shifted > 20'sd127) begin
            sat_val = 8'sd127;
            sat_hit = 1'b1;
        end else if (shifted < -20'sd128) begin
            sat_val = -8'sd128;
            sat_hit = 1'b1;
        end
    end

    assign keep      = in_valid && (phase == '0);
    assign out_valid = (count != '0);
    assign full      = (count == CW'(FIFO_DEPTH));
    assign pop       = out_valid && out_ready;
    assign push      = s1_valid && (!full || pop);
    assign drop      = s1_valid && full && !pop;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= '0;
        end else if (in_valid) begin
            if (phase == PW'(DEC_FACTOR - 1))
                phase <= '0;
            else
                phase <= phase + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= keep;
            if (keep)
                s1_data <= sat_val;
        end
    end

    // Storage carries no reset; out_data is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= s1_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Set events outrank a coincident clear so no event is ever lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_sticky  <= 1'b0;
            drop_sticky <= 1'b0;
        end else begin
            if (keep && sat_hit)
                ovf_sticky <= 1'b1;
            else if (clr_ovf)
                ovf_sticky <= 1'b0;
            if (drop)
                drop_sticky <= 1'b1;
            else if (clr_ovf)
                drop_sticky <= 1'b0;
        end
    end

`ifdef FILTER_OUT_SAT_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_cnt <= '0;
        end else if (keep && sat_hit) begin
            if (clr_ovf)
                sat_cnt <= 16'd1;
            else if (sat_cnt != 16'hFFFF)
                sat_cnt <= sat_cnt + 16'd1;
        end else if (clr_ovf) begin
            sat_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_filter_out_requant.sv
// Randomized bench for filter_out_requant: a DEC_FACTOR=1 and a DEC_FACTOR=4 instance share stimulus and are
// checked every cycle against a queue-based reference model, plus directed checks of the key scenarios.
module tb_filter_out_requant;

    localparam int SHIFT = 7;
    localparam int DEPTH = 4;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic signed [18:0] data_in;
    logic              out_ready;
    logic              clr_ovf;
    logic signed [7:0] od [2];
    logic              ov [2];
    logic              ovf [2];
    logic              drp [2];
`ifdef FILTER_OUT_SAT_CNT_EN
    logic [15:0]       sc [2];
`endif

    int n_cmp;
    int n_bad;

    int m_dec [2];
    int m_phase [2];
    bit m_s1v [2];
    int m_s1d [2];
    int m_q [2][$];
    bit m_ovf [2];
    bit m_drop [2];
    int m_sat [2];

    filter_out_requant #(.DEC_FACTOR(1), .SHIFT(SHIFT), .FIFO_DEPTH(DEPTH)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
        .out_ready(out_ready), .clr_ovf(clr_ovf),
        .out_data(od[0]), .out_valid(ov[0]), .ovf_sticky(ovf[0]), .drop_sticky(drp[0])
`ifdef FILTER_OUT_SAT_CNT_EN
        , .sat_cnt(sc[0])
`endif
    );

    filter_out_requant #(.DEC_FACTOR(4), .SHIFT(SHIFT), .FIFO_DEPTH(DEPTH)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
        .out_ready(out_ready), .clr_ovf(clr_ovf),
        .out_data(od[1]), .out_valid(ov[1]), .ovf_sticky(ovf[1]), .drop_sticky(drp[1])
`ifdef FILTER_OUT_SAT_CNT_EN
        , .sat_cnt(sc[1])
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic signed [31:0] observed,
                                input logic signed [31:0] expected);
        n_cmp++;
        if (observed !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Round-half-up division by 2^SHIFT done with plain integer arithmetic, then clip to int8.
    function automatic void requant(input int x, output int r, output bit s);
        int v;
        int d;
        d = 1 << SHIFT;
        v = x + (1 << (SHIFT - 1));
        if (v >= 0)
            r = v / d;
        else
            r = -((-v + d - 1) / d);
        s = 1'b0;
        if (r > 127) begin
            r = 127;
            s = 1'b1;
        end else if (r < -128) begin
            r = -128;
            s = 1'b1;
        end
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_phase[k] = 0;
            m_s1v[k]   = 1'b0;
            m_s1d[k]   = 0;
            m_q[k].delete();
            m_ovf[k]   = 1'b0;
            m_drop[k]  = 1'b0;
            m_sat[k]   = 0;
        end
    endtask

    task automatic model_edge();
        int  r;
        bit  s;
        bit  keep;
        bit  drop_evt;
        bit  sat_evt;
        int  x;
        x = data_in;
        for (int k = 0; k < 2; k++) begin
            drop_evt = 1'b0;
            if (m_q[k].size() != 0 && out_ready)
                void'(m_q[k].pop_front());
            if (m_s1v[k]) begin
                if (m_q[k].size() < DEPTH)
                    m_q[k].push_back(m_s1d[k]);
                else
                    drop_evt = 1'b1;
            end
            keep = in_valid && (m_phase[k] == 0);
            if (in_valid)
                m_phase[k] = (m_phase[k] + 1) % m_dec[k];
            requant(x, r, s);
            sat_evt    = keep && s;
            m_s1v[k]   = keep;
            if (keep)
                m_s1d[k] = r;
            m_drop[k]  = drop_evt ? 1'b1 : (clr_ovf ? 1'b0 : m_drop[k]);
            m_ovf[k]   = sat_evt ? 1'b1 : (clr_ovf ? 1'b0 : m_ovf[k]);
            if (sat_evt)
                m_sat[k] = clr_ovf ? 1 : ((m_sat[k] < 65535) ? m_sat[k] + 1 : 65535);
            else if (clr_ovf)
                m_sat[k] = 0;
        end
    endtask

    task automatic compare_all();
        string p;
        for (int k = 0; k < 2; k++) begin
            p = (k == 0) ? "dec1" : "dec4";
            check_output({p, " out_valid"}, 32'(ov[k]), 32'(m_q[k].size() != 0));
            check_output({p, " out_data"}, 32'(od[k]), (m_q[k].size() != 0) ? m_q[k][0] : 0);
            check_output({p, " ovf_sticky"}, 32'(ovf[k]), 32'(m_ovf[k]));
            check_output({p, " drop_sticky"}, 32'(drp[k]), 32'(m_drop[k]));
`ifdef FILTER_OUT_SAT_CNT_EN
            check_output({p, " sat_cnt"}, 32'(sc[k]), m_sat[k]);
`endif
        end
    endtask

    // One clock of stimulus: drive at the negedge, advance the model at the posedge, compare at the next negedge.
    task automatic apply_stimulus(input bit iv, input int d, input bit rdy, input bit clr);
        in_valid  = iv;
        data_in   = 19'(d);
        out_ready = rdy;
        clr_ovf   = clr;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        check_output("reset out_valid dec1", 32'(ov[0]), 0);
        check_output("reset out_data dec1", 32'(od[0]), 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int v;
        n_cmp     = 0;
        n_bad     = 0;
        m_dec[0]  = 1;
        m_dec[1]  = 4;
        rst       = 1'b0;
        in_valid  = 1'b0;
        data_in   = '0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        do_reset();

        // Rounding and latency.
        begin
            int rin [4];
            int rexp [4];
            rin  = '{1000, -1000, 64, -65};
            rexp = '{8, -8, 1, -1};
            for (int i = 0; i < 4; i++) begin
                apply_stimulus(1'b1, rin[i], 1'b1, 1'b0);
                check_output("latency edge1 out_valid", 32'(ov[0]), 0);
                apply_stimulus(1'b0, 0, 1'b1, 1'b0);
                check_output("latency edge2 out_valid", 32'(ov[0]), 1);
                check_output("rounding out_data", 32'(od[0]), rexp[i]);
            end
            apply_stimulus(1'b0, 0, 1'b1, 1'b0);
        end

        // Saturation and sticky clear.
        apply_stimulus(1'b1, 20000, 1'b1, 1'b0);
        apply_stimulus(1'b1, -262144, 1'b1, 1'b0);
        check_output("sat first out_data", 32'(od[0]), 127);
        apply_stimulus(1'b0, 0, 1'b1, 1'b0);
        check_output("sat second out_data", 32'(od[0]), -128);
        check_output("sat ovf_sticky", 32'(ovf[0]), 1);
`ifdef FILTER_OUT_SAT_CNT_EN
        check_output("sat sat_cnt", 32'(sc[0]), 2);
`endif
        apply_stimulus(1'b0, 0, 1'b1, 1'b1);
        check_output("clr ovf_sticky", 32'(ovf[0]), 0);

        // Decimation from a known phase, continuous then gapped.
        @(negedge clk);
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            apply_stimulus(1'b1, 128 * i, 1'b1, 1'b0);
            if (i == 2)
                check_output("decim first out_data", 32'(od[1]), 1);
            if (i == 6)
                check_output("decim second out_data", 32'(od[1]), 5);
        end
        for (int i = 0; i < 12; i++)
            apply_stimulus(i % 3 == 0, 128 * (i + 9), 1'b1, 1'b0);
        repeat (3) apply_stimulus(1'b0, 0, 1'b1, 1'b0);

        // Backpressure: overflow, ordered read-back, then full with a simultaneous pop and write.
        apply_stimulus(1'b0, 0, 1'b1, 1'b1);
        for (int i = 1; i <= 6; i++)
            apply_stimulus(1'b1, 128 * i, 1'b0, 1'b0);
        repeat (2) apply_stimulus(1'b0, 0, 1'b0, 1'b0);
        check_output("bp drop_sticky", 32'(drp[0]), 1);
        for (int i = 1; i <= 4; i++) begin
            check_output("bp readback", 32'(od[0]), i);
            apply_stimulus(1'b0, 0, 1'b1, 1'b0);
        end
        check_output("bp drained out_valid", 32'(ov[0]), 0);
        apply_stimulus(1'b0, 0, 1'b0, 1'b1);
        for (int i = 10; i <= 14; i++)
            apply_stimulus(1'b1, 128 * i, 1'b0, 1'b0);
        apply_stimulus(1'b0, 0, 1'b1, 1'b0);
        check_output("bp full pop+write drop_sticky", 32'(drp[0]), 0);
        check_output("bp full pop+write head", 32'(od[0]), 11);
        repeat (6) apply_stimulus(1'b0, 0, 1'b1, 1'b0);

        // Reset with entries queued.
        for (int i = 1; i <= 4; i++)
            apply_stimulus(1'b1, 256 * i, 1'b0, 1'b0);
        check_output("pre-reset out_valid", 32'(ov[0]), 1);
        do_reset();
        apply_stimulus(1'b1, 640, 1'b0, 1'b0);
        check_output("post-reset edge1 out_valid", 32'(ov[1]), 0);
        apply_stimulus(1'b0, 0, 1'b0, 1'b0);
        check_output("post-reset edge2 out_valid", 32'(ov[1]), 1);
        check_output("post-reset out_data", 32'(od[1]), 5);

        // Randomized traffic with occasional clears and resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0)
                v = int'($urandom_range(0, 524287)) - 262144;
            else
                v = int'($urandom_range(0, 40000)) - 20000;
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                apply_stimulus($urandom_range(0, 2) != 0, v, $urandom_range(0, 3) != 0,
                               $urandom_range(0, 30) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
